// File: rtl/mc6502_pkg.sv
// -----------------------------------------------------------------------------
// mc6502_pkg
// Shared definitions for the 6502 interrupt sequencer slice.
//   seq_state_t    : sequencer FSM states, IDLE through DONE
//   int_src_t      : which event started the current sequence
//   VEC_NMI_LO     : low byte address of the NMI vector
//   VEC_IRQ_LO     : low byte address of the IRQ/BRK vector
//   vector_addr()  : vector byte address for a source, low or high byte
//   pushed_status(): status byte as it is written to the stack
// -----------------------------------------------------------------------------
package mc6502_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PUSH_PCH,
        PUSH_PCL,
        PUSH_P,
        VEC_LO,
        VEC_HI,
        DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        SRC_NMI,
        SRC_IRQ,
        SRC_BRK
    } int_src_t;

    localparam logic [15:0] VEC_NMI_LO = 16'hFFFA;
    localparam logic [15:0] VEC_IRQ_LO = 16'hFFFE;

    // IRQ and BRK share one vector; only NMI has its own.
    function automatic logic [15:0] vector_addr(input int_src_t src, input logic hi);
        logic [15:0] base;
        base = (src == SRC_NMI) ? VEC_NMI_LO : VEC_IRQ_LO;
        return base | {15'b0, hi};
    endfunction

    // Bit 5 always reads as 1 on the stack; bit 4 (B) tells the handler
    // whether the entry came from a BRK instruction or a hardware interrupt.
    function automatic logic [7:0] pushed_status(input logic [7:0] psr, input logic brk);
        return (psr & 8'hCF) | 8'h20 | (brk ? 8'h10 : 8'h00);
    endfunction

endpackage

// File: rtl/mc6502_nmi_edge_detector.sv
// -----------------------------------------------------------------------------
// mc6502_nmi_edge_detector
// Latches a pending NMI on a high-to-low transition of the active-low NMI pin.
//   clk     in  : clock
//   rst_x   in  : asynchronous active-low reset
//   nmi_x   in  : NMI pin, active low
//   clear   in  : acknowledge; drops the pending flag
//   pending out : an NMI edge has been seen and not yet serviced
// -----------------------------------------------------------------------------
module mc6502_nmi_edge_detector (
    input  logic clk,
    input  logic rst_x,
    input  logic nmi_x,
    input  logic clear,
    output logic pending
);

    logic nmi_prev;
    logic edge_seen;

    assign edge_seen = nmi_prev & ~nmi_x;

    // The sampler resets to 1 so a pin held low through reset still produces
    // one edge afterwards. A new edge coinciding with an acknowledge wins, so
    // that NMI is not lost.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            nmi_prev <= 1'b1;
            pending  <= 1'b0;
        end else begin
            nmi_prev <= nmi_x;
            pending  <= (pending & ~clear) | edge_seen;
        end
    end

endmodule

// File: rtl/mc6502_interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// mc6502_interrupt_sequencer
// Runs the 6502 interrupt entry: push PCH, PCL, P to the stack page, fetch
// the vector, then load PC/SP and set the I flag in one strobe cycle.
//   clk, rst_x          : clock, asynchronous active-low reset
//   i_nmi_x, i_irq_x    : interrupt pins (NMI edge, IRQ level), active low
//   i_brk               : one-cycle BRK request from the decoder
//   i_boundary          : core is at an instruction boundary
//   i_psr, i_pc, i_sp   : state captured when a sequence starts
//   i_data, i_ready     : bus read data and access-complete handshake
//   o_addr/o_data/o_we/o_re : bus request
//   o_pc/o_set_pc, o_sp/o_set_sp, o_i/o_set_i : register updates at the end
//   o_busy              : a sequence is in progress
// -----------------------------------------------------------------------------
module mc6502_interrupt_sequencer
    import mc6502_pkg::*;
#(
    parameter logic [7:0] STACK_PAGE = 8'h01
) (
    input  logic        clk,
    input  logic        rst_x,
    input  logic        i_nmi_x,
    input  logic        i_irq_x,
    input  logic        i_brk,
    input  logic        i_boundary,
    input  logic [7:0]  i_psr,
    input  logic [15:0] i_pc,
    input  logic [7:0]  i_sp,
    input  logic [7:0]  i_data,
    input  logic        i_ready,
    output logic [15:0] o_addr,
    output logic [7:0]  o_data,
    output logic        o_we,
    output logic        o_re,
    output logic [15:0] o_pc,
    output logic        o_set_pc,
    output logic [7:0]  o_sp,
    output logic        o_set_sp,
    output logic        o_i,
    output logic        o_set_i,
    output logic        o_busy
);

    seq_state_t state;
    seq_state_t state_next;

    int_src_t   src_q;
    int_src_t   start_src;
    logic [15:0] pc_q;
    logic [7:0]  sp_q;
    logic [7:0]  psr_q;
    logic [7:0]  vec_lo_q;
    logic [7:0]  vec_hi_q;

    logic start;
    logic nmi_pending;
    logic nmi_clear;
    logic sp_dec;
    logic load_lo;
    logic load_hi;

    mc6502_nmi_edge_detector u_nmi_edge (
        .clk     (clk),
        .rst_x   (rst_x),
        .nmi_x   (i_nmi_x),
        .clear   (nmi_clear),
        .pending (nmi_pending)
    );

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Snapshot of the interrupted context plus the sequence's working stack
    // pointer. After the three pushes sp_q already holds the final SP.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            src_q    <= SRC_IRQ;
            pc_q     <= 16'h0000;
            sp_q     <= 8'h00;
            psr_q    <= 8'h00;
            vec_lo_q <= 8'h00;
            vec_hi_q <= 8'h00;
        end else begin
            if (start) begin
                src_q <= start_src;
                pc_q  <= i_pc;
                sp_q  <= i_sp;
                psr_q <= i_psr;
            end else if (sp_dec) begin
                sp_q <= sp_q - 8'd1;
            end
            if (load_lo) begin
                vec_lo_q <= i_data;
            end
            if (load_hi) begin
                vec_hi_q <= i_data;
            end
        end
    end

    // Every bus state only advances on i_ready, so a stalled access keeps
    // its address and data stable because both derive from held registers.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        start_src  = SRC_IRQ;
        nmi_clear  = 1'b0;
        sp_dec     = 1'b0;
        load_lo    = 1'b0;
        load_hi    = 1'b0;
        o_addr     = 16'h0000;
        o_data     = 8'h00;
        o_we       = 1'b0;
        o_re       = 1'b0;
        o_pc       = 16'h0000;
        o_set_pc   = 1'b0;
        o_sp       = 8'h00;
        o_set_sp   = 1'b0;
        o_i        = 1'b0;
        o_set_i    = 1'b0;
        o_busy     = 1'b1;

        case (state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_boundary) begin
                    if (nmi_pending) begin
                        start     = 1'b1;
                        start_src = SRC_NMI;
                        nmi_clear = 1'b1;
                    end else if (i_brk) begin
                        start     = 1'b1;
                        start_src = SRC_BRK;
                    end else if (!i_irq_x && !i_psr[2]) begin
                        start     = 1'b1;
                        start_src = SRC_IRQ;
                    end
                end
                if (start) begin
                    state_next = PUSH_PCH;
                end
            end
            PUSH_PCH: begin
                o_we   = 1'b1;
                o_addr = {STACK_PAGE, sp_q};
                o_data = pc_q[15:8];
                if (i_ready) begin
                    sp_dec     = 1'b1;
                    state_next = PUSH_PCL;
                end
            end
            PUSH_PCL: begin
                o_we   = 1'b1;
                o_addr = {STACK_PAGE, sp_q};
                o_data = pc_q[7:0];
                if (i_ready) begin
                    sp_dec     = 1'b1;
                    state_next = PUSH_P;
                end
            end
            PUSH_P: begin
                o_we   = 1'b1;
                o_addr = {STACK_PAGE, sp_q};
                o_data = pushed_status(psr_q, src_q == SRC_BRK);
                if (i_ready) begin
                    sp_dec     = 1'b1;
                    state_next = VEC_LO;
                end
            end
            VEC_LO: begin
                o_re   = 1'b1;
                o_addr = vector_addr(src_q, 1'b0);
                if (i_ready) begin
                    load_lo    = 1'b1;
                    state_next = VEC_HI;
                end
            end
            VEC_HI: begin
                o_re   = 1'b1;
                o_addr = vector_addr(src_q, 1'b1);
                if (i_ready) begin
                    load_hi    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                o_pc       = {vec_hi_q, vec_lo_q};
                o_set_pc   = 1'b1;
                o_sp       = sp_q;
                o_set_sp   = 1'b1;
                o_i        = 1'b1;
                o_set_i    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mc6502_interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mc6502_interrupt_sequencer
// Directed scenarios for the interrupt sequencer. A small bus monitor logs
// stack writes, vector reads and the final strobe values; each scenario task
// compares those logs against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_mc6502_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        rst_x;
    logic        i_nmi_x;
    logic        i_irq_x;
    logic        i_brk;
    logic        i_boundary;
    logic [7:0]  i_psr;
    logic [15:0] i_pc;
    logic [7:0]  i_sp;
    logic [7:0]  i_data;
    logic        i_ready;
    logic [15:0] o_addr;
    logic [7:0]  o_data;
    logic        o_we;
    logic        o_re;
    logic [15:0] o_pc;
    logic        o_set_pc;
    logic [7:0]  o_sp;
    logic        o_set_sp;
    logic        o_i;
    logic        o_set_i;
    logic        o_busy;

    int assertions = 0;
    int failures   = 0;

    logic [15:0] wr_addr [$];
    logic [7:0]  wr_data [$];
    logic [15:0] rd_addr [$];
    int          busy_cnt;
    int          set_i_cnt;
    logic [15:0] done_pc;
    logic [7:0]  done_sp;
    logic        done_i;

    always #5 clk = ~clk;

    mc6502_interrupt_sequencer #(.STACK_PAGE(8'h01)) dut (
        .clk        (clk),
        .rst_x      (rst_x),
        .i_nmi_x    (i_nmi_x),
        .i_irq_x    (i_irq_x),
        .i_brk      (i_brk),
        .i_boundary (i_boundary),
        .i_psr      (i_psr),
        .i_pc       (i_pc),
        .i_sp       (i_sp),
        .i_data     (i_data),
        .i_ready    (i_ready),
        .o_addr     (o_addr),
        .o_data     (o_data),
        .o_we       (o_we),
        .o_re       (o_re),
        .o_pc       (o_pc),
        .o_set_pc   (o_set_pc),
        .o_sp       (o_sp),
        .o_set_sp   (o_set_sp),
        .o_i        (o_i),
        .o_set_i    (o_set_i),
        .o_busy     (o_busy)
    );

    // Vector ROM: NMI handler at C011, IRQ/BRK handler at E022.
    function automatic logic [7:0] vec_rom(input logic [15:0] a);
        case (a)
            16'hFFFA: return 8'h11;
            16'hFFFB: return 8'hC0;
            16'hFFFE: return 8'h22;
            16'hFFFF: return 8'hE0;
            default:  return 8'h00;
        endcase
    endfunction

    assign i_data = vec_rom(o_addr);

    // Inputs change at negedge+1, so at negedge+2 the state and the i_ready
    // value that will be used at the coming posedge are both settled.
    always @(negedge clk) begin
        #2;
        if (o_we && i_ready) begin
            wr_addr.push_back(o_addr);
            wr_data.push_back(o_data);
        end
        if (o_re && i_ready) begin
            rd_addr.push_back(o_addr);
        end
        if (o_busy) busy_cnt++;
        if (o_set_i) set_i_cnt++;
        if (o_set_pc) begin
            done_pc = o_pc;
            done_sp = o_sp;
            done_i  = o_i;
        end
        assertions++;
        if (o_we && o_re) begin
            failures++;
            $display("[TB] FAIL we_re_exclusive: got we=%b re=%b required not both 1", o_we, o_re);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        rd_addr.delete();
        busy_cnt  = 0;
        set_i_cnt = 0;
        done_pc   = 16'h0000;
        done_sp   = 8'h00;
        done_i    = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            step();
            n++;
            if (o_set_pc) seen = 1'b1;
        end
        #2;
        assertions++;
        if (!seen) begin
            failures++;
            $display("[TB] FAIL %s_done_timeout: got no o_set_pc within 40 cycles, required one", name);
        end
    endtask

    task automatic reset_dut();
        rst_x      = 1'b0;
        i_nmi_x    = 1'b1;
        i_irq_x    = 1'b1;
        i_brk      = 1'b0;
        i_boundary = 1'b0;
        i_psr      = 8'h20;
        i_pc       = 16'h0000;
        i_sp       = 8'hFF;
        i_ready    = 1'b1;
        repeat (2) step();
        rst_x = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset_dut();
        assertions++;
        if ({o_addr, o_data, o_pc, o_sp, o_we, o_re, o_set_pc, o_set_sp, o_set_i, o_i, o_busy} !== 55'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got addr=%h data=%h pc=%h sp=%h we=%b re=%b busy=%b required all 0",
                     o_addr, o_data, o_pc, o_sp, o_we, o_re, o_busy);
        end
    endtask

    task automatic test_irq();
        logic [15:0] ea [3];
        logic [7:0]  ed [3];
        ea = '{16'h01FD, 16'h01FC, 16'h01FB};
        ed = '{8'h12, 8'h34, 8'h20};
        clear_log();
        i_psr = 8'h20; i_pc = 16'h1234; i_sp = 8'hFD; i_irq_x = 1'b0; i_boundary = 1'b1;
        step();
        // Scramble the context after the start to prove it was captured.
        i_boundary = 1'b0; i_irq_x = 1'b1; i_pc = 16'hFFFF; i_sp = 8'h00; i_psr = 8'hFF;
        wait_done("irq");
        assertions++;
        if (wr_addr.size() != 3) begin
            failures++;
            $display("[TB] FAIL irq_write_count: got %0d required 3", wr_addr.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                assertions++;
                if ({wr_addr[k], wr_data[k]} !== {ea[k], ed[k]}) begin
                    failures++;
                    $display("[TB] FAIL irq_push%0d: got %h=%h required %h=%h", k, wr_addr[k], wr_data[k], ea[k], ed[k]);
                end
            end
        end
        assertions++;
        if (rd_addr.size() != 2 || rd_addr[0] !== 16'hFFFE || rd_addr[1] !== 16'hFFFF) begin
            failures++;
            $display("[TB] FAIL irq_vector_reads: got %0d reads required FFFE,FFFF", rd_addr.size());
        end
        assertions++;
        if ({done_pc, done_sp, done_i} !== {16'hE022, 8'hFA, 1'b1}) begin
            failures++;
            $display("[TB] FAIL irq_done: got pc=%h sp=%h i=%b required pc=E022 sp=FA i=1", done_pc, done_sp, done_i);
        end
        assertions++;
        if (busy_cnt != 6) begin
            failures++;
            $display("[TB] FAIL irq_latency: got %0d busy cycles required 6", busy_cnt);
        end
        step();
        i_psr = 8'h20;
        assertions++;
        if ({o_set_i, o_set_pc, o_busy} !== 3'b000 || set_i_cnt != 1) begin
            failures++;
            $display("[TB] FAIL irq_set_i_pulse: got set_i now=%b count=%0d required 0 and 1", o_set_i, set_i_cnt);
        end
    endtask

    task automatic test_brk();
        logic [15:0] ea [3];
        logic [7:0]  ed [3];
        ea = '{16'h01FF, 16'h01FE, 16'h01FD};
        ed = '{8'h80, 8'h03, 8'hB1};
        clear_log();
        i_psr = 8'hA1; i_pc = 16'h8003; i_sp = 8'hFF; i_irq_x = 1'b1; i_brk = 1'b1; i_boundary = 1'b1;
        step();
        i_brk = 1'b0; i_boundary = 1'b0;
        wait_done("brk");
        assertions++;
        if (wr_addr.size() != 3) begin
            failures++;
            $display("[TB] FAIL brk_write_count: got %0d required 3", wr_addr.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                assertions++;
                if ({wr_addr[k], wr_data[k]} !== {ea[k], ed[k]}) begin
                    failures++;
                    $display("[TB] FAIL brk_push%0d: got %h=%h required %h=%h", k, wr_addr[k], wr_data[k], ea[k], ed[k]);
                end
            end
        end
        assertions++;
        if (rd_addr.size() != 2 || rd_addr[0] !== 16'hFFFE || {done_pc, done_sp} !== {16'hE022, 8'hFC}) begin
            failures++;
            $display("[TB] FAIL brk_vector: got pc=%h sp=%h required pc=E022 sp=FC via FFFE", done_pc, done_sp);
        end
        // IRQ asserted while I=1 must not start anything.
        step();
        clear_log();
        i_psr = 8'h24; i_irq_x = 1'b0; i_boundary = 1'b1;
        repeat (6) step();
        assertions++;
        if (busy_cnt != 0) begin
            failures++;
            $display("[TB] FAIL irq_masked: got %0d busy cycles required 0", busy_cnt);
        end
        i_irq_x = 1'b1; i_boundary = 1'b0; i_psr = 8'h20;
    endtask

    task automatic test_nmi_priority();
        clear_log();
        i_nmi_x = 1'b0; i_irq_x = 1'b0; i_psr = 8'h20; i_pc = 16'h4000; i_sp = 8'hFD;
        step();
        i_boundary = 1'b1;
        step();
        i_boundary = 1'b0;
        wait_done("nmi");
        assertions++;
        if (rd_addr.size() != 2 || rd_addr[0] !== 16'hFFFA || rd_addr[1] !== 16'hFFFB) begin
            failures++;
            $display("[TB] FAIL nmi_vector_reads: got %0d reads required FFFA,FFFB", rd_addr.size());
        end
        assertions++;
        if (wr_data.size() != 3 || wr_data[0] !== 8'h40 || wr_data[2] !== 8'h20) begin
            failures++;
            $display("[TB] FAIL nmi_pushes: got %0d writes required 40,00,20", wr_data.size());
        end
        assertions++;
        if ({done_pc, done_sp} !== {16'hC011, 8'hFA}) begin
            failures++;
            $display("[TB] FAIL nmi_done: got pc=%h sp=%h required pc=C011 sp=FA", done_pc, done_sp);
        end
        // IRQ still low with I clear: taken at the next boundary.
        step();
        clear_log();
        i_boundary = 1'b1; i_pc = 16'h5000; i_sp = 8'hF0;
        step();
        i_boundary = 1'b0; i_irq_x = 1'b1;
        wait_done("nmi_then_irq");
        assertions++;
        if (rd_addr.size() != 2 || rd_addr[0] !== 16'hFFFE || {done_pc, done_sp} !== {16'hE022, 8'hED}) begin
            failures++;
            $display("[TB] FAIL nmi_then_irq: got pc=%h sp=%h required pc=E022 sp=ED via FFFE", done_pc, done_sp);
        end
        // The NMI was acknowledged; a held-low pin must not retrigger it.
        step();
        clear_log();
        i_boundary = 1'b1;
        repeat (5) step();
        assertions++;
        if (busy_cnt != 0) begin
            failures++;
            $display("[TB] FAIL nmi_cleared: got %0d busy cycles required 0", busy_cnt);
        end
        i_boundary = 1'b0; i_nmi_x = 1'b1;
        step();
    endtask

    task automatic test_sp_wrap();
        logic [15:0] ea [3];
        logic [7:0]  ed [3];
        ea = '{16'h0101, 16'h0100, 16'h01FF};
        ed = '{8'hAB, 8'hCD, 8'h20};
        clear_log();
        i_psr = 8'h20; i_pc = 16'hABCD; i_sp = 8'h01; i_irq_x = 1'b0; i_boundary = 1'b1;
        step();
        i_boundary = 1'b0; i_irq_x = 1'b1;
        wait_done("sp_wrap");
        assertions++;
        if (wr_addr.size() != 3) begin
            failures++;
            $display("[TB] FAIL sp_wrap_write_count: got %0d required 3", wr_addr.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                assertions++;
                if ({wr_addr[k], wr_data[k]} !== {ea[k], ed[k]}) begin
                    failures++;
                    $display("[TB] FAIL sp_wrap_push%0d: got %h=%h required %h=%h", k, wr_addr[k], wr_data[k], ea[k], ed[k]);
                end
            end
        end
        assertions++;
        if (done_sp !== 8'hFE) begin
            failures++;
            $display("[TB] FAIL sp_wrap_final_sp: got %h required FE", done_sp);
        end
        step();
    endtask

    task automatic test_ready_stall();
        clear_log();
        i_psr = 8'h20; i_pc = 16'h1234; i_sp = 8'hFD; i_irq_x = 1'b0; i_boundary = 1'b1;
        step();
        i_boundary = 1'b0; i_irq_x = 1'b1;
        step();
        i_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            assertions++;
            if ({o_we, o_re, o_addr, o_data} !== {1'b1, 1'b0, 16'h01FC, 8'h34}) begin
                failures++;
                $display("[TB] FAIL stall_hold%0d: got we=%b addr=%h data=%h required we=1 addr=01FC data=34",
                         k, o_we, o_addr, o_data);
            end
            if (k < 3) step();
        end
        i_ready = 1'b1;
        wait_done("stall");
        assertions++;
        if (busy_cnt != 9) begin
            failures++;
            $display("[TB] FAIL stall_latency: got %0d busy cycles required 9", busy_cnt);
        end
        assertions++;
        if (wr_addr.size() != 3 || wr_data[1] !== 8'h34 || done_pc !== 16'hE022 || done_sp !== 8'hFA) begin
            failures++;
            $display("[TB] FAIL stall_result: got %0d writes pc=%h sp=%h required 3 writes pc=E022 sp=FA",
                     wr_addr.size(), done_pc, done_sp);
        end
        step();
    endtask

    task automatic test_reset_mid();
        clear_log();
        i_psr = 8'h20; i_pc = 16'h2000; i_sp = 8'hFD; i_irq_x = 1'b1;
        i_nmi_x = 1'b0;
        step();
        i_boundary = 1'b1;
        step();
        i_boundary = 1'b0; i_nmi_x = 1'b1;
        step();
        // Second NMI edge during the sequence: left pending, then lost to reset.
        i_nmi_x = 1'b0;
        step();
        step();
        assertions++;
        if ({o_re, o_addr} !== {1'b1, 16'hFFFA}) begin
            failures++;
            $display("[TB] FAIL reset_mid_in_vec_lo: got re=%b addr=%h required re=1 addr=FFFA", o_re, o_addr);
        end
        rst_x = 1'b0; i_nmi_x = 1'b1;
        #1;
        assertions++;
        if ({o_addr, o_data, o_pc, o_sp, o_we, o_re, o_set_pc, o_set_sp, o_set_i, o_i, o_busy} !== 55'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid_outputs: got addr=%h re=%b busy=%b required all 0", o_addr, o_re, o_busy);
        end
        step();
        rst_x = 1'b1;
        step();
        clear_log();
        i_boundary = 1'b1;
        repeat (5) step();
        assertions++;
        if (busy_cnt != 0) begin
            failures++;
            $display("[TB] FAIL reset_mid_nmi_lost: got %0d busy cycles required 0", busy_cnt);
        end
        i_boundary = 1'b0;
    endtask

    initial begin
        $display("[TB] starting mc6502_interrupt_sequencer bench");
        clear_log();
        test_reset();
        test_irq();
        test_brk();
        test_nmi_priority();
        test_sp_wrap();
        test_ready_stall();
        test_reset_mid();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
